// File: rtl/seg_scan_ctrl_pkg.sv
// rtl/seg_scan_ctrl_pkg.sv - shared types and constants for the seven-segment scan controller
package seg_pkg;
    localparam int SEG_NIBBLE_W = 4;

    // Decimal point polarity, shared with the anode decoder
    localparam logic DP_LIT = 1'b0;
    localparam logic DP_OFF = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_e;
endpackage

// File: rtl/seg_scan_ctrl_slot_timer.sv
// rtl/seg_scan_ctrl_slot_timer.sv - per-slot cycle counter and digit index with explicit wrap
module seg_slot_timer #(
    parameter int NUM_DIG   = 8,
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500,
    localparam int CNT_W    = $clog2(SCAN_DIV),
    localparam int IDX_W    = $clog2(NUM_DIG)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             run_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             in_blank_o,
    output logic             slot_end_o,
    output logic             frame_end_o
);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIG - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (clr_i) begin
            cnt_d = '0;
            idx_d = '0;
        end else if (run_i) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    assign cnt_o       = cnt_q;
    assign idx_o       = idx_q;
    assign in_blank_o  = (cnt_q < CNT_BLANK);
    assign slot_end_o  = (cnt_q == CNT_LAST);
    assign frame_end_o = slot_end_o && (idx_q == IDX_LAST);
endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - double-buffered seven-segment scan controller
// Define SEG_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIG   = 8,
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic                      seg_en,
    input  logic                      load_valid,
    output logic                      load_ready,
    input  logic [4*NUM_DIG-1:0]      load_data,
    input  logic [NUM_DIG-1:0]        load_dp,
    output logic [NUM_DIG-1:0]        dig_sel,
    output logic [SEG_NIBBLE_W-1:0]   seg_data,
    output logic                      seg_DP,
    output logic                      frame_done
);
    localparam int CNT_W   = $clog2(SCAN_DIV);
    localparam int IDX_W   = $clog2(NUM_DIG);
    localparam int FRAME_W = SEG_NIBBLE_W * NUM_DIG;
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

    scan_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic in_blank, slot_end, frame_end;

    logic [FRAME_W-1:0] act_data_q, act_data_d, pend_data_q, pend_data_d;
    logic [NUM_DIG-1:0] act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
    logic               pend_full_q, pend_full_d;
    logic [NUM_DIG-1:0] dig_sel_q, dig_sel_d;
    logic [SEG_NIBBLE_W-1:0] seg_data_q, seg_data_d;
    logic               seg_dp_q, seg_dp_d;
    logic               frame_done_q, frame_done_d;
    logic [NUM_DIG-1:0] show_mask;
    logic               accept;

    seg_slot_timer #(
        .NUM_DIG   (NUM_DIG),
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_slot_timer (
        .clk_i       (sys_clk),
        .rst_i       (sys_rst),
        .clr_i       (~seg_en),
        .run_i       (state_q != IDLE),
        .cnt_o       (cnt),
        .idx_o       (idx),
        .in_blank_o  (in_blank),
        .slot_end_o  (slot_end),
        .frame_end_o (frame_end)
    );

`ifdef SEG_LEADING_ZERO_BLANK_EN
    logic [NUM_DIG-1:0] mask_q, mask_d;

    function automatic logic [NUM_DIG-1:0] lz_mask(input logic [FRAME_W-1:0] d,
                                                   input logic [NUM_DIG-1:0] dp);
        logic seen;
        seen = 1'b0;
        for (int i = NUM_DIG - 1; i >= 0; i--) begin
            if (d[i*SEG_NIBBLE_W +: SEG_NIBBLE_W] != '0) seen = 1'b1;
            lz_mask[i] = seen || dp[i] || (i == 0);
        end
    endfunction

    // Mask follows the active frame, so it only changes when a frame is copied in
    assign mask_d = lz_mask(act_data_d, act_dp_d);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) mask_q <= NUM_DIG'(1);
        else         mask_q <= mask_d;
    end
    assign show_mask = mask_q;
`else
    assign show_mask = '1;
`endif

    assign load_ready = !pend_full_q || frame_end || (state_q == IDLE);
    assign accept     = load_valid && load_ready;

    always_comb begin
        state_d = state_q;
        if (!seg_en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = BLANK;
                BLANK:   if (cnt == BLANK_LAST) state_d = SHOW;
                SHOW:    if (slot_end) state_d = BLANK;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        dig_sel_d    = '0;
        seg_data_d   = seg_data_q;
        seg_dp_d     = seg_dp_q;
        frame_done_d = frame_end;
        act_data_d   = act_data_q;
        act_dp_d     = act_dp_q;
        pend_data_d  = pend_data_q;
        pend_dp_d    = pend_dp_q;
        pend_full_d  = pend_full_q;

        if (seg_en && state_q == SHOW && !in_blank && show_mask[idx])
            dig_sel_d = NUM_DIG'(1) << idx;

        if (state_q == BLANK && cnt == '0) begin
            seg_data_d = act_data_q[int'(idx)*SEG_NIBBLE_W +: SEG_NIBBLE_W];
            seg_dp_d   = act_dp_q[idx] ? DP_LIT : DP_OFF;
        end

        // Idle loads bypass the pending buffer; any stale pending frame is older and dropped
        if (state_q == IDLE) begin
            if (accept) begin
                act_data_d  = load_data;
                act_dp_d    = load_dp;
                pend_full_d = 1'b0;
            end
        end else begin
            if (frame_end && pend_full_q) begin
                act_data_d  = pend_data_q;
                act_dp_d    = pend_dp_q;
                pend_full_d = 1'b0;
            end
            if (accept) begin
                pend_data_d = load_data;
                pend_dp_d   = load_dp;
                pend_full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q      <= IDLE;
            act_data_q   <= '0;
            act_dp_q     <= '0;
            pend_data_q  <= '0;
            pend_dp_q    <= '0;
            pend_full_q  <= 1'b0;
            dig_sel_q    <= '0;
            seg_data_q   <= '0;
            seg_dp_q     <= DP_OFF;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            act_data_q   <= act_data_d;
            act_dp_q     <= act_dp_d;
            pend_data_q  <= pend_data_d;
            pend_dp_q    <= pend_dp_d;
            pend_full_q  <= pend_full_d;
            dig_sel_q    <= dig_sel_d;
            seg_data_q   <= seg_data_d;
            seg_dp_q     <= seg_dp_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign dig_sel    = dig_sel_q;
    assign seg_data   = seg_data_q;
    assign seg_DP     = seg_dp_q;
    assign frame_done = frame_done_q;
endmodule
